// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: four-requester round-robin arbiter steering the winner's data through a 4:1 mux
//   clk, rst_n            clock, asynchronous active-low reset
//   req[3:0]              request per requester
//   din0..din3            requester data buses (DATA_W)
//   gnt[3:0], sel[1:0]    registered one-hot grant and its encoded index
//   out_data, out_valid   combinational mux output and its valid flag
//   out_ready             consumer accepts the current item
module mux_rr_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state;
    logic [1:0] last, win;
    // Scan from the farthest candidate (last itself) back to last+1 so the nearest requester overwrites.
    always_comb begin
        win = last;
        for (int k = 4; k >= 1; k--)
            if (req[last + 2'(k)]) win = last + 2'(k);
    end
    assign out_valid = (state == GRANT) & req[sel];
    assign out_data  = sel == 2'd0 ? din0 : sel == 2'd1 ? din1 : sel == 2'd2 ? din2 : din3;
    // In GRANT, last always equals sel, so a transfer or an abort re-arbitrates from the current owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'b00;
            last  <= 2'b11;
        end else if (state == IDLE || !out_valid || out_ready) begin
            if (|req) begin
                state <= GRANT;
                gnt   <= 4'b0001 << win;
                sel   <= win;
                last  <= win;
            end else begin
                state <= IDLE;
                gnt   <= 4'b0000;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed and randomized checks of mux_rr_arbiter against a round-robin reference model
module tb_mux_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] din0, din1, din2, din3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    int checks = 0;
    int errors = 0;
    int         m_own;
    logic [1:0] m_last, m_sel;

    mux_rr_arbiter #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic int rr(input logic [3:0] r, input int l);
        int w;
        w = -1;
        for (int k = 4; k >= 1; k--)
            if (r[(l + k) % 4]) w = (l + k) % 4;
        return w;
    endfunction

    function automatic logic [7:0] dsel(input logic [1:0] s);
        logic [7:0] d [4];
        d[0] = din0; d[1] = din1; d[2] = din2; d[3] = din3;
        return d[s];
    endfunction

    function automatic logic [3:0] e_gnt();
        return m_own < 0 ? 4'b0000 : 4'(1 << m_own);
    endfunction

    function automatic logic e_valid();
        return m_own >= 0 && req[m_own];
    endfunction

    task automatic model_reset();
        m_own = -1;
        m_last = 2'd3;
        m_sel = 2'd0;
    endtask

    task automatic model_update();
        int w;
        if (!rst_n) model_reset();
        else if (m_own < 0 || !req[m_own] || out_ready) begin
            w = rr(req, m_own < 0 ? int'(m_last) : m_own);
            m_own = w;
            if (w >= 0) begin
                m_last = 2'(w);
                m_sel = 2'(w);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111;
        out_ready = 1'b1;
        din0 = 8'h10; din1 = 8'h11; din2 = 8'h12; din3 = 8'h13;
        model_reset();
        #1;
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'b00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_values gnt=%b sel=%b valid=%b, want 0000 00 0", gnt, sel, out_valid);
        end
        adv();
        checks++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_over_edge gnt=%b valid=%b, want 0000 0", gnt, out_valid);
        end
        #2;
        rst_n = 1'b1;
        req = 4'b1000;
        adv();
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3 || out_data !== 8'h13) begin
            errors++;
            $display("FAIL first_edge_after_release gnt=%b sel=%0d data=%h, want 1000 3 13", gnt, sel, out_data);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] seq [5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        do_reset();
        req = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rotation_idle gnt=%b valid=%b, want 0000 0", gnt, out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            adv();
            checks++;
            if (gnt !== seq[i] || out_valid !== 1'b1 || out_data !== dsel(2'(i % 4))) begin
                errors++;
                $display("FAIL rotation_step%0d gnt=%b valid=%b data=%h, want %b 1 %h",
                         i, gnt, out_valid, out_data, seq[i], dsel(2'(i % 4)));
            end
        end
    endtask

    task automatic test_backpressure();
        int nx;
        nx = 0;
        do_reset();
        req = 4'b0100;
        din2 = 8'hA5;
        adv();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) out_ready = 1'b1;
            #1;
            checks++;
            if (gnt !== 4'b0100 || sel !== 2'd2 || out_data !== 8'hA5 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d gnt=%b sel=%0d data=%h valid=%b, want 0100 2 a5 1",
                         i, gnt, sel, out_data, out_valid);
            end
            if (out_valid && out_ready) nx++;
            adv();
        end
        req = 4'b0000;
        out_ready = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0100 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL regrant_after_xfer gnt=%b valid=%b, want 0100 0", gnt, out_valid);
        end
        if (out_valid && out_ready) nx++;
        adv();
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'd2 || out_valid !== 1'b0 || nx != 1) begin
            errors++;
            $display("FAIL backpressure_idle gnt=%b sel=%0d valid=%b xfers=%0d, want 0000 2 0 1",
                     gnt, sel, out_valid, nx);
        end
    endtask

    task automatic test_priority();
        do_reset();
        req = 4'b0010;
        adv();
        checks++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            errors++;
            $display("FAIL priority_setup gnt=%b sel=%0d, want 0010 1", gnt, sel);
        end
        req = 4'b0011;
        out_ready = 1'b1;
        adv();
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            errors++;
            $display("FAIL priority_wrap gnt=%b sel=%0d, want 0001 0", gnt, sel);
        end
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b1000;
        adv();
        req = 4'b0001;
        #1;
        checks++;
        if (gnt !== 4'b1000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_valid_drop gnt=%b valid=%b, want 1000 0", gnt, out_valid);
        end
        adv();
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_regrant gnt=%b sel=%0d valid=%b, want 0001 0 1", gnt, sel, out_valid);
        end
        req = 4'b0000;
        adv();
        checks++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_to_idle gnt=%b valid=%b, want 0000 0", gnt, out_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        adv();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset gnt=%b sel=%0d valid=%b, want 0000 0 0", gnt, sel, out_valid);
        end
        #1;
        rst_n = 1'b1;
        req = 4'b1000;
        adv();
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL after_async_reset gnt=%b sel=%0d valid=%b, want 1000 3 1", gnt, sel, out_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 2) == 0 || c == 0) req = 4'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            din0 = 8'($urandom); din1 = 8'($urandom); din2 = 8'($urandom); din3 = 8'($urandom);
            #1;
            checks++;
            if (gnt !== e_gnt() || sel !== m_sel || out_valid !== e_valid() || out_data !== dsel(m_sel)) begin
                errors++;
                $display("FAIL rand_model cyc%0d gnt=%b sel=%0d valid=%b data=%h, want %b %0d %b %h",
                         c, gnt, sel, out_valid, out_data, e_gnt(), m_sel, e_valid(), dsel(m_sel));
            end
            checks++;
            if (!$onehot0(gnt) || (gnt != 4'b0000 && gnt !== 4'(1 << sel)) ||
                out_data !== dsel(sel) || (gnt == 4'b0000 && out_valid !== 1'b0)) begin
                errors++;
                $display("FAIL rand_invariant cyc%0d gnt=%b sel=%0d valid=%b data=%h", c, gnt, sel, out_valid, out_data);
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_backpressure();
        test_priority();
        test_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the width of each requester data bus and of out_data.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port req, input, 4 bits: req[i] high means requester i has data to send.
REQ-005 SHALL have ports din0, din1, din2, din3, input, DATA_W each: requester data, stable while the matching req is high.
REQ-006 SHALL have port gnt, output, 4 bits: one-hot grant, or all zero.
REQ-007 SHALL have port sel, output, 2 bits: encoded index of the granted requester, in mux select order (sel = {s1,s0}).
REQ-008 SHALL have port out_data, output, DATA_W: the 4:1 mux output.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a valid item.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the item this cycle.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one requester owns the mux).
REQ-012 SHALL hold a 2-bit last pointer, last, that stores the most recently granted index.
REQ-013 SHALL pick a winner by round robin: search order last+1, last+2, last+3, last (mod 4); the first index with req high wins.
REQ-014 IDLE: if req is non-zero, SHALL register the winner into gnt and sel and update last at the next edge, then enter GRANT; otherwise it stays in IDLE with gnt at 0.
REQ-015 Grant latency SHALL be exactly 1 cycle from req sampled high in IDLE to gnt asserted.
REQ-016 out_data SHALL be combinationally din[sel] (din0 for sel 0 through din3 for sel 3) and SHALL NOT be registered.
REQ-017 out_valid SHALL equal (state == GRANT) & req[sel], combinationally.
REQ-018 A transfer SHALL occur in any cycle where out_valid and out_ready are both high.
REQ-019 On a transfer, the FSM SHALL re-arbitrate in the same cycle using the current req, with last equal to the current sel.
REQ-019a On a transfer with a non-zero winner, it SHALL load the winner at the next edge and stay in GRANT (back-to-back, no bubble).
REQ-019b On a transfer with no requester, it SHALL enter IDLE with gnt at 0.
REQ-020 A granted requester that keeps req high through its transfer SHALL be treated as a new request, ranked lowest by REQ-013.
REQ-021 If req[sel] drops in GRANT without a transfer (abort), the FSM SHALL re-arbitrate as in REQ-019 at the next edge, and no transfer is counted.
REQ-022 While in GRANT with out_valid high and out_ready low, gnt, sel and last SHALL hold.
REQ-023 gnt SHALL never have more than one bit set, and sel SHALL always equal the index of the set bit when gnt is non-zero.
REQ-024 When gnt is zero, sel SHALL hold its last value and out_valid SHALL be 0.

Reset
REQ-025 While rst_n is low, outputs SHALL be: state IDLE, gnt 4'b0000, sel 2'b00, last 2'b11, out_valid 0. The reset takes effect immediately, without waiting for clk.
REQ-026 Because last resets to 3, the first arbitration after reset SHALL give priority in the order 0, 1, 2, 3.
REQ-027 Reset asserted mid-transfer SHALL discard the grant with no transfer recorded. After release, the block SHALL behave as if fresh from reset.
REQ-028 The first rising clk edge with rst_n high SHALL be the first arbitration edge.

Verification
REQ-029 Case 1: after reset, req = 4'b1111 and out_ready = 1 held -> gnt sequence 0001, 0010, 0100, 1000, 0001, one grant per cycle with no bubbles; the bench SHALL check this.
REQ-030 Case 2: req = 4'b0100 with din2 = 8'hA5 and out_ready = 0 for 3 cycles, then 1 -> sel = 2 and out_data = A5 held 4 cycles, one transfer, then IDLE; the bench SHALL check this.
REQ-031 Case 3: last = 1 and req = 4'b0011 on the transfer cycle -> next gnt = 0001, since index 0 outranks index 1; the bench SHALL check this.
REQ-032 Case 4: granted req[3] drops while out_ready = 0 -> out_valid falls in the same cycle, and the next edge grants another requester or enters IDLE; the bench SHALL check this.
REQ-033 Case 5: rst_n pulsed low between clock edges during GRANT -> gnt = 0 and out_valid = 0 immediately; after release with req = 4'b1000 -> gnt = 1000 after one edge; the bench SHALL check this.
REQ-034 Case 6: in a random run, the bench SHALL assert every cycle that gnt is one-hot or zero, that sel matches gnt, and that out_data equals din[sel].
